// File: rtl/z8_pkg.sv
// Shared widths and the load-buffer entry type for the z8 writeback path.
package z8_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 2;
    localparam int unsigned NUM_REGS   = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
        logic                  live;
    } wb_entry_t;

    // One-hot register select used to build the pending-destination mask.
    function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [REG_ADDR_W-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle of the ALU result, load handshake, register-file write and hazard mask
// signals around writeback_unit.
//   master : execute/memory stages + register file + decode (drives alu_*, mem_valid/dest/data)
//   slave  : writeback_unit (drives alu_stall, mem_ready, write_*, pending_mask)
interface writeback_unit_if;

    logic                           alu_valid;
    logic [z8_pkg::REG_ADDR_W-1:0]  alu_dest;
    logic [z8_pkg::DATA_W-1:0]      alu_data;
    logic                           alu_stall;

    logic                           mem_valid;
    logic                           mem_ready;
    logic [z8_pkg::REG_ADDR_W-1:0]  mem_dest;
    logic [z8_pkg::DATA_W-1:0]      mem_data;

    logic [z8_pkg::REG_ADDR_W-1:0]  write_addr;
    logic [z8_pkg::DATA_W-1:0]      write_data;
    logic                           write_enable;

    logic [z8_pkg::NUM_REGS-1:0]    pending_mask;

    modport master (
        output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
        input  alu_stall, mem_ready, write_addr, write_data, write_enable, pending_mask
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
        output alu_stall, mem_ready, write_addr, write_data, write_enable, pending_mask
    );

endinterface

// File: rtl/wb_fifo.sv
// DEPTH-entry load-result FIFO with squash-by-destination.
//   clk, reset      : clock, synchronous active-low reset
//   push/push_entry : enqueue an entry (ignored when full)
//   pop             : dequeue the head (ignored when empty)
//   squash/squash_dest : clear live on every stored entry writing squash_dest
//   head            : entry at the read pointer
//   count           : occupancy, 0..DEPTH
//   live_vec/dest_vec : live bit and destination of every slot
module wb_fifo
    import z8_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                push,
    input  wb_entry_t                           push_entry,
    input  logic                                pop,
    input  logic                                squash,
    input  logic [REG_ADDR_W-1:0]               squash_dest,
    output wb_entry_t                           head,
    output logic [$clog2(DEPTH):0]              count,
    output logic [DEPTH-1:0]                    live_vec,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    dest_vec
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign push_ok = push && (count != CNT_W'(DEPTH));
    assign pop_ok  = pop  && (count != '0);
    assign head    = mem_q[rd_ptr];

    // Live bits are cleared on pop, so live implies the slot is occupied.
    always_comb begin
        live_vec = '0;
        dest_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live_vec[i] = mem_q[i].live;
            dest_vec[i] = mem_q[i].dest;
        end
    end

    // Squash first, then pop/push; push targets a free slot so it is never squashed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (squash) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem_q[i].live && (mem_q[i].dest == squash_dest)) begin
                        mem_q[i].live <= 1'b0;
                    end
                end
            end
            if (pop_ok) begin
                mem_q[rd_ptr].live <= 1'b0;
                rd_ptr             <= rd_ptr + PTR_W'(1);
            end
            if (push_ok) begin
                mem_q[wr_ptr] <= push_entry;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Single owner of the register-file write port: merges ALU results and buffered
// load results into one registered write stream, squashes stale loads on WAW,
// and exports the pending-destination mask for RAW stalls in decode.
//   clk, reset : clock, synchronous active-low reset
//   bus        : writeback_unit_if.slave (alu_*, mem_*, write_*, pending_mask)
module writeback_unit
    import z8_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    writeback_unit_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t                          head;
    wb_entry_t                          push_entry;
    logic [CNT_W-1:0]                   count;
    logic [DEPTH-1:0]                   live_vec;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]   dest_vec;
    logic                               full;
    logic                               push;
    logic                               pop;
    logic                               alu_accept;

    logic                               we_q;
    logic [REG_ADDR_W-1:0]              addr_q;
    logic [DATA_W-1:0]                  data_q;
    logic [NUM_REGS-1:0]                pending;

    // Arbitration: a full FIFO wins, then the ALU, then a non-empty FIFO.
    always_comb begin
        full       = (count == CNT_W'(DEPTH));
        alu_accept = bus.alu_valid && !full;
        pop        = full || (!bus.alu_valid && (count != '0));
        push       = bus.mem_valid && bus.mem_ready;
        push_entry = '{dest: bus.mem_dest, data: bus.mem_data, live: 1'b1};
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .squash      (alu_accept),
        .squash_dest (bus.alu_dest),
        .head        (head),
        .count       (count),
        .live_vec    (live_vec),
        .dest_vec    (dest_vec)
    );

    // Output stage; a dead head consumes the slot with write_enable low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (alu_accept) begin
            we_q   <= 1'b1;
            addr_q <= bus.alu_dest;
            data_q <= bus.alu_data;
        end else if (pop) begin
            we_q <= head.live;
            if (head.live) begin
                addr_q <= head.dest;
                data_q <= head.data;
            end
        end else begin
            we_q <= 1'b0;
        end
    end

    // Pending destinations: live buffered loads plus the write in flight.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_vec[i]) begin
                pending = pending | onehot_reg(dest_vec[i]);
            end
        end
        if (we_q) begin
            pending = pending | onehot_reg(addr_q);
        end
    end

    assign bus.mem_ready    = reset && !full;
    assign bus.alu_stall    = full;
    assign bus.write_enable = we_q;
    assign bus.write_addr   = addr_q;
    assign bus.write_data   = data_q;
    assign bus.pending_mask = pending;

    property p_no_alu_while_stalled;
        @(posedge clk) disable iff (!reset) !(bus.alu_valid && bus.alu_stall);
    endproperty
    a_no_alu_while_stalled: assert property (p_no_alu_while_stalled);

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed vector table, hand sequences for the
// multi-cycle corners, then randomized traffic against a queue-based model.
module tb_writeback_unit;

    localparam int unsigned DEPTH = 2;

    logic clk;
    logic reset;
    writeback_unit_if bus ();

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [1:0] ad, input logic [15:0] adata,
                         input logic mv, input logic [1:0] md, input logic [15:0] mdata);
        bus.alu_valid = av;
        bus.alu_dest  = ad;
        bus.alu_data  = adata;
        bus.mem_valid = mv;
        bus.mem_dest  = md;
        bus.mem_data  = mdata;
    endtask

    // Apply inputs for one cycle and sample 1 time unit after the edge.
    task automatic cyc(input logic av, input logic [1:0] ad, input logic [15:0] adata,
                       input logic mv, input logic [1:0] md, input logic [15:0] mdata);
        drive(av, ad, adata, mv, md, mdata);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic we, input logic [1:0] wa,
                              input logic [15:0] wd, input logic [3:0] mask,
                              input logic rdy, input logic stall);
        chk({tag, ".we"},    32'(bus.write_enable), 32'(we));
        chk({tag, ".addr"},  32'(bus.write_addr),   32'(wa));
        chk({tag, ".data"},  32'(bus.write_data),   32'(wd));
        chk({tag, ".mask"},  32'(bus.pending_mask), 32'(mask));
        chk({tag, ".ready"}, 32'(bus.mem_ready),    32'(rdy));
        chk({tag, ".stall"}, 32'(bus.alu_stall),    32'(stall));
    endtask

    typedef struct {
        logic        av;
        logic [1:0]  ad;
        logic [15:0] adata;
        logic        mv;
        logic [1:0]  md;
        logic [15:0] mdata;
        logic        we;
        logic [1:0]  wa;
        logic [15:0] wd;
        logic [3:0]  mask;
        logic        rdy;
        logic        stall;
    } vec_t;

    function automatic vec_t mk(input logic av, input logic [1:0] ad, input logic [15:0] adata,
                                input logic mv, input logic [1:0] md, input logic [15:0] mdata,
                                input logic we, input logic [1:0] wa, input logic [15:0] wd,
                                input logic [3:0] mask, input logic rdy, input logic stall);
        vec_t v;
        v.av = av; v.ad = ad; v.adata = adata;
        v.mv = mv; v.md = md; v.mdata = mdata;
        v.we = we; v.wa = wa; v.wd = wd;
        v.mask = mask; v.rdy = rdy; v.stall = stall;
        return v;
    endfunction

    // Reference model: queue of buffered loads plus the output register.
    typedef struct {
        logic [1:0]  dest;
        logic [15:0] data;
        logic        live;
    } ld_t;

    ld_t         mq[$];
    logic        m_we;
    logic [1:0]  m_addr;
    logic [15:0] m_data;

    task automatic model_edge(input logic rst_n, input logic av, input logic [1:0] ad,
                              input logic [15:0] adata, input logic mv, input logic [1:0] md,
                              input logic [15:0] mdata);
        ld_t e;
        logic full;
        logic push_ok;
        if (!rst_n) begin
            mq.delete();
            m_we = 1'b0; m_addr = 2'd0; m_data = 16'd0;
            return;
        end
        full    = (mq.size() == DEPTH);
        push_ok = mv && !full;
        if (full || (!av && mq.size() > 0)) begin
            e = mq.pop_front();
            m_we = e.live;
            if (e.live) begin
                m_addr = e.dest;
                m_data = e.data;
            end
        end else if (av) begin
            m_we = 1'b1; m_addr = ad; m_data = adata;
            foreach (mq[i]) if (mq[i].dest == ad) mq[i].live = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (push_ok) begin
            e.dest = md; e.data = mdata; e.live = 1'b1;
            mq.push_back(e);
        end
    endtask

    function automatic logic [3:0] model_mask();
        logic [3:0] m = 4'd0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].dest] = 1'b1;
        if (m_we) m[m_addr] = 1'b1;
        return m;
    endfunction

    vec_t tbl[9];

    initial begin
        // Reset state
        reset = 1'b0;
        drive(1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("reset_release.ready", 32'(bus.mem_ready), 32'd1);

        // ALU write, single load, and WAW squash of a buffered load
        tbl[0] = mk(1, 2'd2, 16'hBEEF, 0, 2'd0, 16'h0000, 1, 2'd2, 16'hBEEF, 4'b0100, 1, 0);
        tbl[1] = mk(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000, 0, 2'd2, 16'hBEEF, 4'b0000, 1, 0);
        tbl[2] = mk(0, 2'd0, 16'h0000, 1, 2'd1, 16'h1234, 0, 2'd2, 16'hBEEF, 4'b0010, 1, 0);
        tbl[3] = mk(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000, 1, 2'd1, 16'h1234, 4'b0010, 1, 0);
        tbl[4] = mk(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000, 0, 2'd1, 16'h1234, 4'b0000, 1, 0);
        tbl[5] = mk(0, 2'd0, 16'h0000, 1, 2'd1, 16'h0001, 0, 2'd1, 16'h1234, 4'b0010, 1, 0);
        tbl[6] = mk(1, 2'd1, 16'h0002, 0, 2'd0, 16'h0000, 1, 2'd1, 16'h0002, 4'b0010, 1, 0);
        tbl[7] = mk(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000, 0, 2'd1, 16'h0002, 4'b0000, 1, 0);
        tbl[8] = mk(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000, 0, 2'd1, 16'h0002, 4'b0000, 1, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].av, tbl[i].ad, tbl[i].adata, tbl[i].mv, tbl[i].md, tbl[i].mdata);
            expect_out($sformatf("tbl%0d", i), tbl[i].we, tbl[i].wa, tbl[i].wd,
                       tbl[i].mask, tbl[i].rdy, tbl[i].stall);
        end

        // Fill to DEPTH behind the ALU, stall, then drain R0, ALU, R3
        cyc(1, 2'd2, 16'hC001, 1, 2'd0, 16'hA000);
        expect_out("fill_a", 1, 2'd2, 16'hC001, 4'b0101, 1, 0);
        cyc(1, 2'd2, 16'hC002, 1, 2'd3, 16'hA003);
        expect_out("fill_b", 1, 2'd2, 16'hC002, 4'b1101, 0, 1);
        cyc(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000);
        expect_out("fill_c", 1, 2'd0, 16'hA000, 4'b1001, 1, 0);
        cyc(1, 2'd2, 16'hC003, 0, 2'd0, 16'h0000);
        expect_out("fill_d", 1, 2'd2, 16'hC003, 4'b1100, 1, 0);
        cyc(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000);
        expect_out("fill_e", 1, 2'd3, 16'hA003, 4'b1000, 1, 0);
        cyc(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000);
        expect_out("fill_f", 0, 2'd3, 16'hA003, 4'b0000, 1, 0);

        // Same-cycle ALU and load to R2: load is younger and survives
        cyc(1, 2'd2, 16'hD00A, 1, 2'd2, 16'hD00B);
        expect_out("same_a", 1, 2'd2, 16'hD00A, 4'b0100, 1, 0);
        cyc(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000);
        expect_out("same_b", 1, 2'd2, 16'hD00B, 4'b0100, 1, 0);
        cyc(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000);
        expect_out("same_c", 0, 2'd2, 16'hD00B, 4'b0000, 1, 0);

        // Reset with two loads buffered drops them
        cyc(1, 2'd1, 16'hE001, 1, 2'd0, 16'hB000);
        cyc(1, 2'd1, 16'hE002, 1, 2'd3, 16'hB003);
        expect_out("rst_fill", 1, 2'd1, 16'hE002, 4'b1011, 0, 1);
        drive(0, 2'd0, 16'h0000, 1, 2'd2, 16'h5555);
        reset = 1'b0;
        #1;
        chk("rst_low.ready", 32'(bus.mem_ready), 32'd0);
        @(posedge clk);
        #1;
        expect_out("rst_edge", 0, 2'd0, 16'h0000, 4'b0000, 0, 0);
        reset = 1'b1;
        drive(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000);
        #1;
        chk("rst_high.ready", 32'(bus.mem_ready), 32'd1);
        cyc(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000);
        expect_out("rst_idle1", 0, 2'd0, 16'h0000, 4'b0000, 1, 0);
        cyc(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000);
        expect_out("rst_idle2", 0, 2'd0, 16'h0000, 4'b0000, 1, 0);

        // Randomized traffic against the model
        mq.delete();
        m_we = 1'b0; m_addr = 2'd0; m_data = 16'd0;
        reset = 1'b0;
        cyc(0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000);
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst;
            logic        r_av;
            logic [1:0]  r_ad;
            logic [15:0] r_adata;
            logic        r_mv;
            logic [1:0]  r_md;
            logic [15:0] r_mdata;
            r_rst   = ($urandom_range(0, 149) != 0);
            r_av    = (mq.size() != DEPTH) && ($urandom_range(0, 2) == 0);
            r_ad    = 2'($urandom_range(0, 3));
            r_adata = 16'($urandom);
            r_mv    = ($urandom_range(0, 1) == 1);
            r_md    = 2'($urandom_range(0, 3));
            r_mdata = 16'($urandom);
            reset = r_rst;
            cyc(r_av, r_ad, r_adata, r_mv, r_md, r_mdata);
            model_edge(r_rst, r_av, r_ad, r_adata, r_mv, r_md, r_mdata);
            chk($sformatf("rnd%0d.we", c),    32'(bus.write_enable), 32'(m_we));
            chk($sformatf("rnd%0d.addr", c),  32'(bus.write_addr),   32'(m_addr));
            chk($sformatf("rnd%0d.data", c),  32'(bus.write_data),   32'(m_data));
            chk($sformatf("rnd%0d.mask", c),  32'(bus.pending_mask), 32'(model_mask()));
            chk($sformatf("rnd%0d.ready", c), 32'(bus.mem_ready),
                32'(r_rst && (mq.size() < DEPTH)));
            chk($sformatf("rnd%0d.stall", c), 32'(bus.alu_stall),    32'(mq.size() == DEPTH));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Single owner of the z8 core's register-file write port: merges single-cycle ALU results and handshaked load results into one registered `write_addr`/`write_data`/`write_enable` stream. Sits between the execute/memory stages and the 4×16-bit register file. Buffers up to two load results, squashes stale loads on WAW conflicts, and exports a pending-destination mask so decode can stall on RAW hazards.

## Interface

Parameters:
- `DEPTH`, 2, load FIFO entries (power of two, ≥2)

Ports:
- `clk`  input  1  core clock; all state on rising edge
- `reset`  input  1  synchronous, active-low reset (0 = reset)
- `alu_valid`  input  1  ALU result present this cycle; no backpressure except `alu_stall`
- `alu_dest`  input  2  ALU destination register
- `alu_data`  input  16  ALU result
- `alu_stall`  output  1  upstream must hold `alu_valid` low while this is high
- `mem_valid`  input  1  load result offered
- `mem_ready`  output  1  load FIFO can accept
- `mem_dest`  input  2  load destination register
- `mem_data`  input  16  load data
- `write_addr`  output  2  register-file write address (registered)
- `write_data`  output  16  register-file write data (registered)
- `write_enable`  output  1  register-file write strobe (registered)
- `pending_mask`  output  4  bit i = a live write to Ri is buffered or in the output stage

## Operation

- Load handshake: transfer when `mem_valid && mem_ready` at a rising edge. `mem_ready = reset && count < DEPTH`; `count` is registered and does not depend on same-cycle pop.
- Each FIFO entry holds {dest, data, live}. Pushed entries have live = 1.
- Arbitration per cycle, in priority order:
  - `count == DEPTH`: the FIFO head drives the port. `alu_stall = 1`.
  - Otherwise, if `alu_valid`: the ALU result drives the port.
  - Otherwise, if the FIFO is non-empty: the head drives the port.
- A popped head with live = 0 is discarded. In that case `write_enable` goes low next cycle and the port slot is wasted.
- WAW squash: when an ALU result is accepted, every FIFO entry present that cycle with `dest == alu_dest` is cleared to live = 0. These entries are older by in-order issue.
  - A load pushed in the same cycle is younger and is not squashed.
- `alu_valid` while `alu_stall = 1` is a protocol violation. Behaviour is undefined; an assertion flags it.
- `pending_mask`: OR of onehot(dest) over live FIFO entries and the output stage (`write_enable` high), computed from registered state.

## Timing

- Reset (`reset` = 0 at an edge) has the following effect:
  - `write_enable`, `write_addr`, `write_data`, `count`, and all live bits go to 0.
  - `pending_mask` = 0 and `alu_stall` = 0.
  - `mem_ready` = 0 while `reset` is low.
- A reset mid-operation drops all buffered loads without writing them.
- ALU latency: accepted in cycle t → `write_*` asserted in cycle t+1 → register file updated at the end of t+1.
- Load latency: pushed at the end of t → head in t+1 → `write_*` in t+2 (minimum, empty FIFO, no ALU activity).
- Push and pop in the same cycle are legal at any count < DEPTH; count is unchanged.
- Pointers wrap modulo DEPTH. Full/empty is taken from a separate `$clog2(DEPTH)+1`-bit count.
- `write_enable` drops to 0 in any cycle with nothing to write. `write_addr`/`write_data` hold their previous values when `write_enable` is 0.

## Structure

- Package `z8_pkg`:
  - `DATA_W = 16`, `REG_ADDR_W = 2`, `NUM_REGS = 4`.
  - `typedef struct packed {logic [REG_ADDR_W-1:0] dest; logic [DATA_W-1:0] data; logic live;} wb_entry_t`.
- Sub-module `wb_fifo`: DEPTH-entry `wb_entry_t` FIFO with push/pop, count, and a per-entry squash-by-dest port that exposes all entries for mask generation.
- Top level contains the arbiter, output register, and `pending_mask` logic.

## Test plan

- Reset, then `alu_valid`=1, dest=2, data=16'hBEEF in cycle 1 → cycle 2: `write_enable`=1, `write_addr`=2, `write_data`=16'hBEEF. Cycle 3: `write_enable`=0.
- Load dest=1, data=16'h1234 into an idle unit → `write_*` two cycles later. `pending_mask`=4'b0010 from push+1 until `write_enable` drops.
- Two loads (R0, R3) followed by continuous `alu_valid` → `mem_ready`=0 and `alu_stall`=1 at count=2. Head R0 writes first. ALU is accepted once `alu_stall` drops. Final write order: R0, ALU, then R3 only after ALU idles.
- Load R1=16'h0001 buffered, then ALU R1=16'h0002 → only 16'h0002 reaches R1. The squashed entry pops with `write_enable`=0 and clears its `pending_mask` bit.
- ALU R2 and load R2 in the same cycle → ALU writes first, then the load writes; R2 ends with the load value.
- Reset asserted with 2 loads buffered → next cycle: `count`=0, `pending_mask`=0, no writes, `mem_ready`=1 after `reset` returns high.
